// File: rtl/flit_sender_pkg.sv
// Shared flit layout, opcode and sizing definitions for the flit sender and its FIFO.
// Positions marked _OFS are relative to PayloadWidth (the header sits above the payload).
package flit_sender_pkg;

    localparam int DEF_PAYLOAD_WIDTH = 32;
    localparam int DEF_LG_NUMPROCS   = 3;
    localparam int fifo_lg_size      = 4;

    // Header field widths; they sum to FLIT_HDR_W with the valid bit on top.
    localparam int OP_W      = 5;
    localparam int TAG_W     = 8;
    localparam int CONTEXT_W = 8;
    localparam int RANK_W    = 12;
    localparam int SRC_W     = 8;
    localparam int DST_W     = 8;
    localparam int FLIT_HDR_W = OP_W + TAG_W + CONTEXT_W + RANK_W + SRC_W + DST_W + 1;

    localparam int OP_OFS      = 0;
    localparam int TAG_OFS     = OP_OFS + OP_W;
    localparam int CONTEXT_OFS = TAG_OFS + TAG_W;
    localparam int RANK_OFS    = CONTEXT_OFS + CONTEXT_W;
    localparam int SRC_OFS     = RANK_OFS + RANK_W;
    localparam int DST_OFS     = SRC_OFS + SRC_W;
    localparam int VALID_OFS   = DST_OFS + DST_W;

    localparam int FlitWidth     = DEF_PAYLOAD_WIDTH + FLIT_HDR_W;
    localparam int ValidBitPos   = FlitWidth - 1;
    localparam int ChildrenPos   = FlitWidth;
    localparam int ChildrenWidth = DEF_LG_NUMPROCS;

    typedef enum logic [OP_W-1:0] {
        OP_NOP       = 5'd0,
        OP_BCAST     = 5'd1,
        OP_REDUCE    = 5'd2,
        OP_ALLREDUCE = 5'd3,
        OP_BARRIER   = 5'd4,
        OP_SCATTER   = 5'd5,
        OP_GATHER    = 5'd6,
        OP_ALLGATHER = 5'd7,
        OP_P2P_SEND  = 5'd8,
        OP_P2P_ACK   = 5'd9
    } flit_op_e;

    typedef struct packed {
        logic                 valid;
        logic [DST_W-1:0]     dst;
        logic [SRC_W-1:0]     src;
        logic [RANK_W-1:0]    rank;
        logic [CONTEXT_W-1:0] context_id;
        logic [TAG_W-1:0]     tag;
        logic [OP_W-1:0]      op;
    } flit_hdr_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } rd_state_e;

    function automatic int flit_width(input int payload_width);
        return payload_width + FLIT_HDR_W;
    endfunction

    function automatic int valid_bit_pos(input int payload_width);
        return payload_width + VALID_OFS;
    endfunction

endpackage

// File: rtl/flit_sender_credit_counter.sv
// Downstream credit tracker: one credit reserved per issued read, returned by credit_in
// pulses or by discarded bubbles; saturates at MaxCredits with a sticky overflow flag.
module credit_counter #(
    parameter int MaxCredits  = 16,
    parameter int CreditWidth = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue,
    input  logic                   credit_in,
    input  logic                   bubble_return,
    output logic [CreditWidth-1:0] credit_cnt,
    output logic                   credit_overflow
);

    localparam int SumWidth = CreditWidth + 2;
    localparam logic [SumWidth-1:0] MaxExt = SumWidth'(MaxCredits);

    logic [SumWidth-1:0] next_sum;

    // Two guard bits keep the +2 / -1 arithmetic from wrapping before the clamp check;
    // issue only happens with a nonzero count so the sum never goes negative.
    always_comb begin
        next_sum = {2'b00, credit_cnt}
                 - SumWidth'(issue)
                 + SumWidth'(credit_in)
                 + SumWidth'(bubble_return);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt      <= CreditWidth'(MaxCredits);
            credit_overflow <= 1'b0;
        end else if (next_sum > MaxExt) begin
            credit_cnt      <= CreditWidth'(MaxCredits);
            credit_overflow <= 1'b1;
        end else begin
            credit_cnt      <= next_sum[CreditWidth-1:0];
        end
    end

endmodule

// File: rtl/flit_sender.sv
// Drains the input flit FIFO onto the outbound link under credit flow control, dropping bubbles.
// Optional statistics counters are built when FLIT_SENDER_STATS_EN is defined.
module flit_sender
    import flit_sender_pkg::*;
#(
    parameter int lg_numprocs  = 3,
    parameter int PayloadWidth = 32,
    parameter int MaxCredits   = 16,
    parameter int CreditWidth  = 5,
    localparam int FlitW       = PayloadWidth + FLIT_HDR_W,
    localparam int WordW       = FlitW + lg_numprocs
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   link_en,
    input  logic                   fifo_empty,
    input  logic [WordW-1:0]       fifo_buf_out,
    output logic                   fifo_rd_en,
    input  logic                   credit_in,
    output logic [FlitW-1:0]       flit_out,
    output logic [lg_numprocs-1:0] children_out,
    output logic                   flit_valid,
    output logic [CreditWidth-1:0] credit_cnt,
    output logic                   credit_overflow,
    output logic [15:0]            sent_cnt,
    output logic [15:0]            drop_cnt
);

    localparam int VBit = FlitW - 1;

    rd_state_e state;
    logic      rd_pending;
    logic      word_valid;
    logic      bubble_return;

    assign rd_pending    = (state == PEND);
    assign word_valid    = fifo_buf_out[VBit];
    assign bubble_return = rd_pending && !word_valid;

    assign fifo_rd_en = link_en && !fifo_empty && (credit_cnt != '0) && !rst;

    // State tracks whether last cycle issued a read, i.e. whether fifo_buf_out is fresh now.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            flit_out     <= '0;
            children_out <= '0;
            flit_valid   <= 1'b0;
        end else begin
            flit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_rd_en) state <= PEND;
                end
                PEND: begin
                    if (word_valid) begin
                        flit_out     <= fifo_buf_out[FlitW-1:0];
                        children_out <= fifo_buf_out[WordW-1:FlitW];
                        flit_valid   <= 1'b1;
                    end
                    if (!fifo_rd_en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    credit_counter #(
        .MaxCredits (MaxCredits),
        .CreditWidth(CreditWidth)
    ) u_credit_counter (
        .clk            (clk),
        .rst            (rst),
        .issue          (fifo_rd_en),
        .credit_in      (credit_in),
        .bubble_return  (bubble_return),
        .credit_cnt     (credit_cnt),
        .credit_overflow(credit_overflow)
    );

`ifdef FLIT_SENDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (flit_valid)    sent_cnt <= sent_cnt + 16'd1;
            if (bubble_return) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign sent_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_flit_sender.sv
// Randomized scoreboard bench for flit_sender: a queue-based FIFO and credit model predict
// reads and credits; a negedge monitor matches delivered flits against expected ones.
module tb_flit_sender;

    localparam int LG   = 3;
    localparam int PW   = 32;
    localparam int MAXC = 16;
    localparam int CW   = 5;
    localparam int FW   = PW + 50;
    localparam int WW   = FW + LG;
    localparam int VB   = FW - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          link_en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [WW-1:0] fifo_buf_out = '0;
    logic          fifo_rd_en;
    logic          credit_in = 1'b0;
    logic [FW-1:0] flit_out;
    logic [LG-1:0] children_out;
    logic          flit_valid;
    logic [CW-1:0] credit_cnt;
    logic          credit_overflow;
    logic [15:0]   sent_cnt;
    logic [15:0]   drop_cnt;

    flit_sender #(
        .lg_numprocs (LG),
        .PayloadWidth(PW),
        .MaxCredits  (MAXC),
        .CreditWidth (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .link_en        (link_en),
        .fifo_empty     (fifo_empty),
        .fifo_buf_out   (fifo_buf_out),
        .fifo_rd_en     (fifo_rd_en),
        .credit_in      (credit_in),
        .flit_out       (flit_out),
        .children_out   (children_out),
        .flit_valid     (flit_valid),
        .credit_cnt     (credit_cnt),
        .credit_overflow(credit_overflow),
        .sent_cnt       (sent_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [WW-1:0] w;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic [WW-1:0] fq[$];

    // Reference state: credits available, sticky overflow, word popped last cycle,
    // whether a flit is shown this cycle, and statistics totals.
    int            m_cred = MAXC;
    bit            m_ovf  = 1'b0;
    bit            m_pend = 1'b0;
    logic [WW-1:0] m_pend_w = '0;
    bit            m_outv = 1'b0;
    int            m_sent = 0;
    int            m_drop = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [WW-1:0] mkword(input bit v);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        r[VB] = v;
        return r[WW-1:0];
    endfunction

    task automatic push(input logic [WW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: drive inputs, check against the model, then advance the model.
    task automatic step(input bit le, input bit ci, input bit r);
        bit            exp_rd;
        bit            bub;
        logic [WW-1:0] w;
        int            nc;
        link_en   = le;
        credit_in = ci;
        rst       = r;
        #1;
        exp_rd = le && (fq.size() > 0) && (m_cred > 0) && !r;
        chk("rd_en", 128'(fifo_rd_en), 128'(exp_rd));
        chk("credit_cnt", 128'(credit_cnt), 128'(m_cred));
        chk("credit_overflow", 128'(credit_overflow), 128'(m_ovf));
`ifdef FLIT_SENDER_STATS_EN
        chk("sent_cnt", 128'(sent_cnt), 128'(m_sent % 65536));
        chk("drop_cnt", 128'(drop_cnt), 128'(m_drop % 65536));
`else
        chk("sent_cnt", 128'(sent_cnt), 128'(0));
        chk("drop_cnt", 128'(drop_cnt), 128'(0));
`endif
        bub = m_pend && !m_pend_w[VB];
        w = '0;
        if (exp_rd) begin
            w = fq.pop_front();
            if (w[VB]) sb.push_back('{w, cyc + 2});
        end
        nc = m_cred - int'(exp_rd) + int'(ci) + int'(bub);
        @(posedge clk);
        #1;
        if (r) begin
            m_cred = MAXC; m_ovf = 1'b0; m_pend = 1'b0; m_outv = 1'b0;
            m_sent = 0; m_drop = 0;
            sb.delete();
            fq.delete();
        end else begin
            if (m_outv) m_sent++;
            if (bub) m_drop++;
            m_outv   = m_pend && m_pend_w[VB];
            m_pend   = exp_rd;
            m_pend_w = w;
            if (nc > MAXC) begin
                nc    = MAXC;
                m_ovf = 1'b1;
            end
            m_cred = nc;
            if (exp_rd) fifo_buf_out = w;
        end
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        push(mkword(1'b1));
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_flit_out", 128'(flit_out), 128'(0));
        chk("rst_children", 128'(children_out), 128'(0));
        chk("rst_flit_valid", 128'(flit_valid), 128'(0));
    endtask

    // Monitor: every presented flit must match the oldest expectation, on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (flit_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 128'(flit_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("flit_out", 128'(flit_out), 128'(e.w[FW-1:0]));
                    chk("children_out", 128'(children_out), 128'(e.w[WW-1:FW]));
                    chk("latency", 128'(cyc), 128'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missing_flit", 128'(flit_valid), 128'(1));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [WW-1:0] w;
        @(negedge clk);
        do_reset();

        // Three valid flits drained back to back.
        for (int i = 0; i < 3; i++) push(mkword(1'b1));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        chk("burst3_credits", 128'(credit_cnt), 128'(13));

        // Known children/payload pattern.
        do_reset();
        w = '0;
        w[VB] = 1'b1;
        w[31:0] = 32'hDEADBEEF;
        w[WW-1:FW] = 3'b101;
        push(w);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("children_101", 128'(children_out), 128'(5));
        chk("payload_deadbeef", 128'(flit_out[31:0]), 128'(32'hDEADBEEF));
        step(1'b1, 1'b0, 1'b0);

        // Bubble between valid flits: dropped and its credit handed back.
        do_reset();
        push(mkword(1'b1));
        push(mkword(1'b0));
        push(mkword(1'b1));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        chk("bubble_net_credits", 128'(credit_cnt), 128'(MAXC - 2));

        // Exhaust credits, stall, then a single credit releases one more read.
        do_reset();
        for (int i = 0; i < 20; i++) push(mkword(1'b1));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("exhausted_credits", 128'(credit_cnt), 128'(0));
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);

        // Randomized traffic with link toggling, bubbles and simultaneous issue/credit.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit le;
            bit ci;
            if ($urandom_range(0, 2) == 0) push(mkword($urandom_range(0, 99) < 85));
            le = ($urandom_range(0, 9) != 0);
            ci = (m_cred < MAXC) ? ($urandom_range(0, 1) == 1) : 1'b0;
            step(le, ci, 1'b0);
        end
        for (int i = 0; i < 40; i++) step(1'b1, (m_cred < MAXC), 1'b0);
        chk("random_drained_fifo", 128'(fifo_empty), 128'(1));

        // Credit returned while already full: clamp and sticky overflow.
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        chk("ovf_clamp", 128'(credit_cnt), 128'(MAXC));
        chk("ovf_set", 128'(credit_overflow), 128'(1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // Reset the cycle after a read issues: the read is discarded.
        push(mkword(1'b1));
        push(mkword(1'b1));
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("midrst_valid", 128'(flit_valid), 128'(0));
        chk("midrst_credits", 128'(credit_cnt), 128'(MAXC));
        chk("midrst_ovf_clear", 128'(credit_overflow), 128'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
